// File: rtl/wb_arbiter.sv
// Write-back arbiter: schedules up to two of four requesters per cycle onto the
// register file's two write ports, round-robin, with same-destination conflict skip.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREQ   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     we1,
  output logic [ADDR_W-1:0]        waddr1,
  output logic [DATA_W-1:0]        wdata1,
  output logic                     we2,
  output logic [ADDR_W-1:0]        waddr2,
  output logic [DATA_W-1:0]        wdata2
);

  localparam int RR_W = $clog2(NREQ);

  logic [ADDR_W-1:0] addr [NREQ];
  logic [DATA_W-1:0] data [NREQ];
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   x0;
  logic [NREQ-1:0]   grant;
  logic [RR_W-1:0]   rr;
  logic [RR_W-1:0]   rr_next;
  logic [RR_W-1:0]   idx;
  logic [RR_W-1:0]   s1_idx;
  logic [RR_W-1:0]   s2_idx;
  logic              s1_vld;
  logic              s2_vld;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr[i] = req_addr[i*ADDR_W +: ADDR_W];
      data[i] = req_data[i*DATA_W +: DATA_W];
      x0[i]   = req_valid[i] && (addr[i] == '0);
      elig[i] = req_valid[i] && (addr[i] != '0);
    end
  end

  // Walk from rr; a second request aimed at slot 1's register is skipped, not blocking.
  always_comb begin
    s1_vld = 1'b0;
    s2_vld = 1'b0;
    s1_idx = '0;
    s2_idx = '0;
    idx    = '0;
    grant  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr + RR_W'(k);
      if (elig[idx]) begin
        if (!s1_vld) begin
          s1_vld = 1'b1;
          s1_idx = idx;
        end else if (!s2_vld && (addr[idx] != addr[s1_idx])) begin
          s2_vld = 1'b1;
          s2_idx = idx;
        end
      end
    end
    if (s1_vld) grant[s1_idx] = 1'b1;
    if (s2_vld) grant[s2_idx] = 1'b1;
  end

  always_comb begin
    rr_next = rr;
    if (s2_vld)      rr_next = s2_idx + RR_W'(1);
    else if (s1_vld) rr_next = s1_idx + RR_W'(1);
  end

  // Nothing is accepted while reset is held, x0 discards included.
  assign req_ready = (grant | x0) & {NREQ{rst}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr     <= '0;
      we1    <= 1'b0;
      waddr1 <= '0;
      wdata1 <= '0;
      we2    <= 1'b0;
      waddr2 <= '0;
      wdata2 <= '0;
    end else begin
      rr     <= rr_next;
      we1    <= s1_vld;
      waddr1 <= s1_vld ? addr[s1_idx] : '0;
      wdata1 <= s1_vld ? data[s1_idx] : '0;
      we2    <= s2_vld;
      waddr2 <= s2_vld ? addr[s2_idx] : '0;
      wdata2 <= s2_vld ? data[s2_idx] : '0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based grant model checked every cycle, plus
// directed vectors with hand-computed grants, port values and final register state.
module tb_wb_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         we1, we2;
  logic [4:0]   waddr1, waddr2;
  logic [31:0]  wdata1, wdata2;

  int total = 0;
  int bad   = 0;

  logic [1:0]  rr_m;
  logic [37:0] m_p1, m_p2;
  logic [31:0] rf [32];

  wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] addr_of(input int i);
    return req_addr[i*5 +: 5];
  endfunction

  function automatic logic [31:0] data_of(input int i);
    return req_data[i*32 +: 32];
  endfunction

  // Candidates in search order; slot 2 is the first later candidate whose register differs.
  function automatic void model(input logic [3:0] v, input logic [1:0] rr,
                                output logic [3:0] rdy, output int s1, output int s2);
    int order[$];
    rdy = '0;
    s1  = -1;
    s2  = -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (int'(rr) + k) % 4;
      if (v[i]) begin
        if (addr_of(i) == 5'd0) rdy[i] = 1'b1;
        else order.push_back(i);
      end
    end
    if (order.size() > 0) begin
      s1 = order[0];
      rdy[s1] = 1'b1;
      for (int j = 1; j < order.size(); j++) begin
        if (addr_of(order[j]) != addr_of(s1)) begin
          s2 = order[j];
          rdy[s2] = 1'b1;
          break;
        end
      end
    end
  endfunction

  logic [3:0] p_rdy;
  int         p_s1, p_s2;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_m <= 2'd0;
      m_p1 <= '0;
      m_p2 <= '0;
    end else begin
      model(req_valid, rr_m, p_rdy, p_s1, p_s2);
      m_p1 <= (p_s1 >= 0) ? {1'b1, addr_of(p_s1), data_of(p_s1)} : 38'd0;
      m_p2 <= (p_s2 >= 0) ? {1'b1, addr_of(p_s2), data_of(p_s2)} : 38'd0;
      if (p_s2 >= 0)      rr_m <= 2'((p_s2 + 1) % 4);
      else if (p_s1 >= 0) rr_m <= 2'((p_s1 + 1) % 4);
    end
  end

  always @(posedge clk) begin
    if (we1) rf[waddr1] <= wdata1;
    if (we2) rf[waddr2] <= wdata2;
  end

  logic [3:0] c_rdy;
  int         c_s1, c_s2;

  always @(negedge clk) begin
    model(req_valid, rr_m, c_rdy, c_s1, c_s2);
    check("model_ready", {60'd0, req_ready}, {60'd0, (rst ? c_rdy : 4'b0000)});
    check("model_port1", {26'd0, we1, waddr1, wdata1}, {26'd0, m_p1});
    check("model_port2", {26'd0, we2, waddr2, wdata2}, {26'd0, m_p2});
  end

  task automatic set_req(input logic [3:0] v,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] a3,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    req_valid = v;
    req_addr  = {a3, a2, a1, a0};
    req_data  = {d3, d2, d1, d0};
  endtask

  // Call just after a rising edge with inputs applied; checks ready mid-cycle and ports after the edge.
  task automatic cyc(input string name, input logic [3:0] exp_rdy,
                     input logic [37:0] exp_p1, input logic [37:0] exp_p2);
    @(negedge clk);
    #1;
    check({name, "_ready"}, {60'd0, req_ready}, {60'd0, exp_rdy});
    @(posedge clk);
    #1;
    check({name, "_port1"}, {26'd0, we1, waddr1, wdata1}, {26'd0, exp_p1});
    check({name, "_port2"}, {26'd0, we2, waddr2, wdata2}, {26'd0, exp_p2});
  endtask

  initial begin
    rst = 1'b0;
    set_req(4'b1111, 5'd1, 5'd2, 5'd3, 5'd4, 32'd100, 32'd101, 32'd102, 32'd103);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {60'd0, req_ready}, 64'd0);
    check("rst_port1", {26'd0, we1, waddr1, wdata1}, 64'd0);
    check("rst_port2", {26'd0, we2, waddr2, wdata2}, 64'd0);
    rst = 1'b1;

    cyc("c1", 4'b0011, {1'b1, 5'd1, 32'd100}, {1'b1, 5'd2, 32'd101});
    set_req(4'b1100, 5'd1, 5'd2, 5'd3, 5'd4, 32'd100, 32'd101, 32'd102, 32'd103);
    cyc("c2", 4'b1100, {1'b1, 5'd3, 32'd102}, {1'b1, 5'd4, 32'd103});

    set_req(4'b0100, 5'd0, 5'd0, 5'd7, 5'd0, 32'd0, 32'd0, 32'hDEADBEEF, 32'd0);
    cyc("single", 4'b0100, {1'b1, 5'd7, 32'hDEADBEEF}, 38'd0);

    set_req(4'b0011, 5'd0, 5'd5, 5'd0, 5'd0, 32'h99, 32'h11, 32'd0, 32'd0);
    cyc("x0", 4'b0011, {1'b1, 5'd5, 32'h11}, 38'd0);

    set_req(4'b1000, 5'd0, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 32'd0, 32'h55);
    cyc("rr_to0", 4'b1000, {1'b1, 5'd10, 32'h55}, 38'd0);

    set_req(4'b1011, 5'd9, 5'd9, 5'd0, 5'd4, 32'hA, 32'hB, 32'd0, 32'hC);
    cyc("confl_n", 4'b1001, {1'b1, 5'd9, 32'hA}, {1'b1, 5'd4, 32'hC});
    set_req(4'b0010, 5'd0, 5'd9, 5'd0, 5'd0, 32'd0, 32'hB, 32'd0, 32'd0);
    cyc("confl_n1", 4'b0010, {1'b1, 5'd9, 32'hB}, 38'd0);

    set_req(4'b1000, 5'd0, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 32'd0, 32'h66);
    cyc("rr_to0b", 4'b1000, {1'b1, 5'd10, 32'h66}, 38'd0);
    check("x9_final", {32'd0, rf[9]}, 64'hB);

    set_req(4'b1111, 5'd11, 5'd12, 5'd13, 5'd14, 32'h1000, 32'h1001, 32'h1002, 32'h1003);
    cyc("fair0", 4'b0011, {1'b1, 5'd11, 32'h1000}, {1'b1, 5'd12, 32'h1001});
    cyc("fair1", 4'b1100, {1'b1, 5'd13, 32'h1002}, {1'b1, 5'd14, 32'h1003});
    cyc("fair2", 4'b0011, {1'b1, 5'd11, 32'h1000}, {1'b1, 5'd12, 32'h1001});
    cyc("fair3", 4'b1100, {1'b1, 5'd13, 32'h1002}, {1'b1, 5'd14, 32'h1003});

    set_req(4'b0001, 5'd15, 5'd0, 5'd0, 5'd0, 32'h77, 32'd0, 32'd0, 32'd0);
    cyc("rr_to1", 4'b0001, {1'b1, 5'd15, 32'h77}, 38'd0);

    #2;
    rst = 1'b0;
    #1;
    check("async_ready", {60'd0, req_ready}, 64'd0);
    check("async_port1", {26'd0, we1, waddr1, wdata1}, 64'd0);
    check("async_port2", {26'd0, we2, waddr2, wdata2}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_req(4'b1111, 5'd1, 5'd2, 5'd3, 5'd4, 32'h200, 32'h201, 32'h202, 32'h203);
    cyc("post_rst", 4'b0011, {1'b1, 5'd1, 32'h200}, {1'b1, 5'd2, 32'h201});

    set_req(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
